// File: rtl/mc_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mc_instr_sequencer
// Purpose  : Multicycle fetch / execute / PC-update control FSM for the
//            16-bit datapath, including conditional jumps and HLT.
// Revision : 1.0 - initial release
// ============================================================================
module mc_instr_sequencer #(
   parameter int ADDR_W      = 4,
   parameter int EXEC_CYCLES = 4
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              run,
   input  logic [31:0]       instr_in,
   input  logic              imem_ready,
   input  logic              flag_zero,
   input  logic              flag_sign,
   input  logic              flag_carry,
   input  logic              flag_ovf,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       ir,
   output logic              ir_load,
   output logic              exec_en,
   output logic              halted,
   output logic [15:0]       instr_count
);

   localparam logic [4:0] c_OP_JMP = 5'd12;
   localparam logic [4:0] c_OP_JZ  = 5'd13;
   localparam logic [4:0] c_OP_JNZ = 5'd14;
   localparam logic [4:0] c_OP_JC  = 5'd15;
   localparam logic [4:0] c_OP_JS  = 5'd16;
   localparam logic [4:0] c_OP_JV  = 5'd17;
   localparam logic [4:0] c_OP_HLT = 5'd31;

   localparam logic [3:0] c_EXEC_LOAD = 4'(EXEC_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_NEXT  = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_pc;
   logic [31:0]         r_ir;
   logic                r_ir_load;
   logic                r_exec_en;
   logic                r_halted;
   logic [15:0]         r_instr_count;
   logic [3:0]          r_exec_cnt;

   logic [4:0]          w_opcode;
   logic [ADDR_W-1:0]   w_target;
   logic                w_is_jump;
   logic                w_taken;
   logic                w_is_hlt;
   logic                w_exec_last;

   assign w_opcode    = r_ir[31:27];
   assign w_target    = r_ir[ADDR_W-1:0];
   assign w_is_hlt    = (w_opcode == c_OP_HLT);
   assign w_exec_last = (r_exec_cnt == 4'd0);

   always_comb begin
      w_is_jump = 1'b1;
      w_taken   = 1'b0;
      case (w_opcode)
         c_OP_JMP: w_taken = 1'b1;
         c_OP_JZ:  w_taken = flag_zero;
         c_OP_JNZ: w_taken = ~flag_zero;
         c_OP_JC:  w_taken = flag_carry;
         c_OP_JS:  w_taken = flag_sign;
         c_OP_JV:  w_taken = flag_ovf;
         default:  w_is_jump = 1'b0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (run) w_state_nxt = S_FETCH;
         S_FETCH: if (imem_ready) w_state_nxt = S_EXEC;
         S_EXEC:  if (w_exec_last) w_state_nxt = S_NEXT;
         S_NEXT: begin
            if (w_is_hlt)  w_state_nxt = S_HALT;
            else if (run)  w_state_nxt = S_FETCH;
            else           w_state_nxt = S_IDLE;
         end
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sys_rst) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Strobes are registered decodes of the current state, so each one
   // appears in the cycle after the state that caused it.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         r_pc          <= '0;
         r_ir          <= '0;
         r_ir_load     <= 1'b0;
         r_exec_en     <= 1'b0;
         r_halted      <= 1'b0;
         r_instr_count <= '0;
         r_exec_cnt    <= '0;
      end else begin
         r_ir_load <= (r_state == S_FETCH) && imem_ready;
         r_exec_en <= (r_state == S_EXEC) && (r_exec_cnt == c_EXEC_LOAD)
                      && !w_is_jump && !w_is_hlt;
         r_halted  <= (r_state == S_HALT);

         if ((r_state == S_FETCH) && imem_ready) begin
            r_ir       <= instr_in;
            r_exec_cnt <= c_EXEC_LOAD;
         end else if ((r_state == S_EXEC) && !w_exec_last) begin
            r_exec_cnt <= r_exec_cnt - 4'd1;
         end

         if (r_state == S_NEXT) begin
            r_instr_count <= r_instr_count + 16'd1;
            if (!w_is_hlt) begin
               if (w_is_jump && w_taken) r_pc <= w_target;
               else                      r_pc <= r_pc + ADDR_W'(1);
            end
         end
      end
   end

   assign pc          = r_pc;
   assign ir          = r_ir;
   assign ir_load     = r_ir_load;
   assign exec_en     = r_exec_en;
   assign halted      = r_halted;
   assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_mc_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_instr_sequencer
// Purpose  : Scoreboard bench for mc_instr_sequencer (fetch, jumps, HLT,
//            stall, wrap and mid-instruction reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_instr_sequencer;

   logic        clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        run = 1'b0;
   logic [31:0] instr_in;
   logic        imem_ready = 1'b1;
   logic        flag_zero = 1'b0, flag_sign = 1'b0, flag_carry = 1'b0, flag_ovf = 1'b0;
   logic [3:0]  pc;
   logic [31:0] ir;
   logic        ir_load, exec_en, halted;
   logic [15:0] instr_count;

   mc_instr_sequencer #(.ADDR_W(4), .EXEC_CYCLES(4)) dut (
      .clk(clk), .sys_rst(sys_rst), .run(run), .instr_in(instr_in),
      .imem_ready(imem_ready), .flag_zero(flag_zero), .flag_sign(flag_sign),
      .flag_carry(flag_carry), .flag_ovf(flag_ovf), .pc(pc), .ir(ir),
      .ir_load(ir_load), .exec_en(exec_en), .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:15];
   assign instr_in = mem[pc];

   typedef struct { logic [3:0] pc; logic [31:0] ir; } exp_t;
   exp_t sb[$];
   exp_t e_item;
   int   exec_t[$];
   int   cyc = 0, n_exec = 0;
   int   total = 0, bad = 0;
   logic [3:0]  m_pc;
   logic [15:0] m_cnt;

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] tgt);
      logic [31:0] w;
      w = 32'h0012_3450;
      w[31:27] = op;
      w[3:0]   = tgt;
      return w;
   endfunction

   function automatic bit is_dp(input logic [4:0] op);
      return !((op >= 5'd12 && op <= 5'd17) || op == 5'd31);
   endfunction

   // Scoreboard consumer: every IR load must match the next queued fetch.
   always @(negedge clk) begin
      cyc++;
      if (ir_load === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_load pc=%0d ir=%h (nothing expected)", pc, ir);
         end else begin
            e_item = sb.pop_front();
            if (ir !== e_item.ir || pc !== e_item.pc) begin
               bad++;
               $display("FAIL sb_load got pc=%0d ir=%h expected pc=%0d ir=%h",
                        pc, ir, e_item.pc, e_item.ir);
            end
         end
      end
      if (exec_en === 1'b1) begin
         n_exec++;
         exec_t.push_back(cyc);
         total++;
         if (!is_dp(ir[31:27]) || ir_load !== 1'b0) begin
            bad++;
            $display("FAIL exec_en_legal got opcode=%0d ir_load=%b expected datapath op, ir_load=0",
                     ir[31:27], ir_load);
         end
      end
   end

   task automatic wait_load(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ir_load === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_cnt(input logic [15:0] tgt, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (instr_count === tgt) begin ok = 1'b1; break; end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      sys_rst = 1'b1;
      run     = 1'b0;
      repeat (2) @(negedge clk);
      sys_rst = 1'b0;
      m_pc  = 4'd0;
      m_cnt = 16'd0;
   endtask

   // Runs exactly one instruction from the model PC, then parks in IDLE.
   task automatic step(input string nm);
      bit ok_l, ok_c;
      sb.push_back('{pc: m_pc, ir: mem[m_pc]});
      run = 1'b1;
      wait_load(ok_l);
      run = 1'b0;
      m_cnt = m_cnt + 16'd1;
      wait_cnt(m_cnt, ok_c);
      total++;
      if (!ok_l || !ok_c) begin
         bad++;
         $display("FAIL %s_timeout got load_seen=%b count=%0d expected load_seen=1 count=%0d",
                  nm, ok_l, instr_count, m_cnt);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++;
      if (pc !== 4'd0 || ir !== 32'd0 || ir_load !== 1'b0 || exec_en !== 1'b0 ||
          halted !== 1'b0 || instr_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_vals got pc=%0d ir=%h ld=%b ex=%b h=%b cnt=%0d expected all zero",
                  pc, ir, ir_load, exec_en, halted, instr_count);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      exec_t.delete();
      for (int i = 0; i < 3; i++) sb.push_back('{pc: 4'(i), ir: mem[i]});
      run = 1'b1;
      for (int i = 0; i < 3; i++) wait_load(ok);
      run = 1'b0;
      m_cnt = 16'd3;
      wait_cnt(m_cnt, ok);
      m_pc = 4'd3;
      total++;
      if (!ok || pc !== m_pc || instr_count !== m_cnt) begin
         bad++;
         $display("FAIL b2b_end got pc=%0d cnt=%0d expected pc=%0d cnt=%0d", pc, instr_count, m_pc, m_cnt);
      end
      total++;
      if (exec_t.size() != 3) begin
         bad++;
         $display("FAIL b2b_exec_count got %0d expected 3", exec_t.size());
      end else begin
         for (int i = 1; i < 3; i++) begin
            total++;
            if (exec_t[i] - exec_t[i-1] != 6) begin
               bad++;
               $display("FAIL b2b_exec_spacing got %0d expected 6", exec_t[i] - exec_t[i-1]);
            end
         end
      end
   endtask

   task automatic test_jz();
      int ne;
      ne = n_exec;
      flag_zero = 1'b1;
      step("jz_taken");
      m_pc = 4'd9;
      total++;
      if (pc !== m_pc || n_exec != ne) begin
         bad++;
         $display("FAIL jz_taken got pc=%0d execs=%0d expected pc=%0d execs=%0d", pc, n_exec, m_pc, ne);
      end
      step("jmp_back");
      m_pc = 4'd3;
      total++;
      if (pc !== m_pc) begin
         bad++;
         $display("FAIL jmp_back got pc=%0d expected %0d", pc, m_pc);
      end
      flag_zero = 1'b0;
      step("jz_not_taken");
      m_pc = 4'd4;
      total++;
      if (pc !== m_pc || n_exec != ne) begin
         bad++;
         $display("FAIL jz_not_taken got pc=%0d execs=%0d expected pc=%0d execs=%0d", pc, n_exec, m_pc, ne);
      end
   endtask

   task automatic test_halt();
      bit ok_l, ok_c;
      step("dp_before_hlt");
      m_pc = 4'd5;
      total++;
      if (pc !== m_pc) begin
         bad++;
         $display("FAIL pre_hlt_pc got %0d expected %0d", pc, m_pc);
      end
      sb.push_back('{pc: m_pc, ir: mem[m_pc]});
      run = 1'b1;
      wait_load(ok_l);
      m_cnt = m_cnt + 16'd1;
      wait_cnt(m_cnt, ok_c);
      total++;
      if (!ok_l || !ok_c || halted !== 1'b0) begin
         bad++;
         $display("FAIL hlt_early got load=%b cnt_ok=%b halted=%b expected 1 1 0", ok_l, ok_c, halted);
      end
      @(negedge clk);
      total++;
      if (halted !== 1'b1) begin
         bad++;
         $display("FAIL hlt_rise got halted=%b expected 1", halted);
      end
      for (int i = 0; i < 10; i++) begin
         run = 1'($urandom_range(0, 1));
         @(negedge clk);
         total++;
         if (halted !== 1'b1 || pc !== m_pc || instr_count !== m_cnt) begin
            bad++;
            $display("FAIL hlt_hold got h=%b pc=%0d cnt=%0d expected h=1 pc=%0d cnt=%0d",
                     halted, pc, instr_count, m_pc, m_cnt);
         end
      end
      run = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      run        = 1'b1;
      imem_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         total++;
         if (ir_load !== 1'b0 || ir !== 32'd0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold got ld=%b ir=%h h=%b expected 0 0 0", ir_load, ir, halted);
         end
      end
      sb.push_back('{pc: 4'd0, ir: mem[0]});
      imem_ready = 1'b1;
      @(negedge clk);
      total++;
      if (ir_load !== 1'b1) begin
         bad++;
         $display("FAIL stall_release got ir_load=%b expected 1", ir_load);
      end
      @(negedge clk);
      total++;
      if (exec_en !== 1'b1) begin
         bad++;
         $display("FAIL stall_exec got exec_en=%b expected 1", exec_en);
      end
      run = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (instr_count !== 16'd0) begin
         bad++;
         $display("FAIL stall_early_retire got cnt=%0d expected 0", instr_count);
      end
      @(negedge clk);
      m_cnt = 16'd1;
      m_pc  = 4'd1;
      total++;
      if (instr_count !== m_cnt || pc !== m_pc) begin
         bad++;
         $display("FAIL stall_retire got cnt=%0d pc=%0d expected cnt=%0d pc=%0d", instr_count, pc, m_cnt, m_pc);
      end
   endtask

   task automatic test_wrap();
      step("jmp_15");
      m_pc = 4'd15;
      total++;
      if (pc !== m_pc) begin
         bad++;
         $display("FAIL jmp_15 got pc=%0d expected %0d", pc, m_pc);
      end
      step("wrap");
      m_pc = 4'd0;
      total++;
      if (pc !== m_pc || instr_count !== m_cnt) begin
         bad++;
         $display("FAIL wrap got pc=%0d cnt=%0d expected pc=%0d cnt=%0d", pc, instr_count, m_pc, m_cnt);
      end
   endtask

   task automatic test_mid_exec_reset();
      bit ok;
      step("dp_at_0");
      m_pc = 4'd1;
      sb.push_back('{pc: m_pc, ir: mem[m_pc]});
      run = 1'b1;
      wait_load(ok);
      @(negedge clk);
      sys_rst = 1'b1;
      @(negedge clk);
      total++;
      if (!ok || pc !== 4'd0 || ir !== 32'd0 || ir_load !== 1'b0 || exec_en !== 1'b0 ||
          halted !== 1'b0 || instr_count !== 16'd0) begin
         bad++;
         $display("FAIL midexec_reset got ok=%b pc=%0d ir=%h ld=%b ex=%b h=%b cnt=%0d expected 1 and all zero",
                  ok, pc, ir, ir_load, exec_en, halted, instr_count);
      end
      sys_rst = 1'b0;
      m_pc  = 4'd0;
      m_cnt = 16'd1;
      sb.push_back('{pc: m_pc, ir: mem[m_pc]});
      wait_load(ok);
      run = 1'b0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL midexec_resume got load_seen=0 expected 1");
      end
      wait_cnt(m_cnt, ok);
      total++;
      if (!ok || pc !== 4'd1) begin
         bad++;
         $display("FAIL midexec_retire got pc=%0d cnt=%0d expected pc=1 cnt=1", pc, instr_count);
      end
   endtask

   task automatic test_cond_jumps();
      logic [4:0] ops [4];
      logic [3:0] want;
      bit         taken;
      ops = '{5'd14, 5'd15, 5'd16, 5'd17};
      for (int k = 0; k < 4; k++) begin
         for (int v = 0; v < 2; v++) begin
            mem[0] = mk(ops[k], 4'd7);
            do_reset();
            {flag_zero, flag_carry, flag_sign, flag_ovf} = {4{~1'(v)}};
            case (k)
               0: flag_zero  = 1'(v);
               1: flag_carry = 1'(v);
               2: flag_sign  = 1'(v);
               default: flag_ovf = 1'(v);
            endcase
            taken = (k == 0) ? (v == 0) : (v == 1);
            want  = taken ? 4'd7 : 4'd1;
            step("cond_jump");
            total++;
            if (pc !== want) begin
               bad++;
               $display("FAIL cond_jump op=%0d flag=%0d got pc=%0d expected %0d", ops[k], v, pc, want);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      mem[0]  = mk(5'd1, 4'd0);
      mem[1]  = mk(5'd2, 4'd1);
      mem[2]  = mk(5'd3, 4'd2);
      mem[3]  = mk(5'd13, 4'd9);
      mem[4]  = mk(5'd0, 4'd4);
      mem[5]  = mk(5'd31, 4'd0);
      mem[9]  = mk(5'd12, 4'd3);
      mem[15] = mk(5'd20, 4'd6);
      test_reset();
      test_back_to_back();
      test_jz();
      test_halt();
      mem[1] = mk(5'd12, 4'd15);
      test_stall();
      test_wrap();
      test_mid_exec_reset();
      test_cond_jumps();
      repeat (2) @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_drain got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
